minbd_sidebuf_ctrl: RTL and testbench

Side-buffer controller for the MinBD deflection router. It captures the flit that the eject/buffer stage diverts to the side buffer (sbuff) and holds it in a small FIFO. It reinjects buffered flits into empty router input slots using round-robin selection. If the FIFO stays starved too long, it forces a redirection swap with an occupied slot. It sits between the eject/buffer stage and the permutation stage input.

---
 rtl/minbd_sidebuf_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_minbd_sidebuf_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/minbd_sidebuf_ctrl.sv
// Side-buffer controller for the MinBD deflection router: buffers diverted flits and
// reinjects them round-robin into empty slots, forcing a swap when starved too long.
module minbd_sidebuf_ctrl #(
  parameter int FLIT_W       = 11,
  parameter int DEPTH        = 4,
  parameter int REDIR_THRESH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLIT_W-1:0]          sbuff,
  input  logic [FLIT_W-1:0]          in_e,
  input  logic [FLIT_W-1:0]          in_w,
  input  logic [FLIT_W-1:0]          in_n,
  input  logic [FLIT_W-1:0]          in_s,
  output logic [FLIT_W-1:0]          out_e,
  output logic [FLIT_W-1:0]          out_w,
  output logic [FLIT_W-1:0]          out_n,
  output logic [FLIT_W-1:0]          out_s,
  output logic                       sb_full,
  output logic [$clog2(DEPTH):0]     sb_count,
  output logic                       redir,
  output logic                       overflow
);

  // state | meaning
  // IDLE  | FIFO empty
  // WAIT  | FIFO non-empty, starve counter running
  // REDIR | forced swap pending
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REDIR} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (REDIR_THRESH > 1) ? $clog2(REDIR_THRESH) : 1;

  state_t              state_q, state_d;
  logic [FLIT_W-1:0]   mem_q [DEPTH];
  logic [FLIT_W-1:0]   mem_d [DEPTH];
  logic [FLIT_W-1:0]   out_q [4];
  logic [FLIT_W-1:0]   out_d [4];
  logic [FLIT_W-1:0]   slot_in [4];
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_tmp;
  logic [CW-1:0]       count_q, count_d, cnt_tmp;
  logic [1:0]          rr_q, rr_d, pick;
  logic [SW-1:0]       starve_q, starve_d;
  logic                full_q, full_d, redir_q, redir_d, ovf_q, ovf_d;
  logic                found, pop, swap, sb_push;
  logic [FLIT_W-1:0]   head;

  assign slot_in[0] = in_e;
  assign slot_in[1] = in_w;
  assign slot_in[2] = in_n;
  assign slot_in[3] = in_s;
  assign head       = mem_q[rd_ptr_q];

  // First empty slot at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    for (int i = 0; i < 4; i++) begin
      if (!found && !slot_in[rr_q + 2'(i)][FLIT_W-1]) begin
        found = 1'b1;
        pick  = rr_q + 2'(i);
      end
    end
  end

  always_comb begin
    out_d    = slot_in;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    rr_d     = rr_q;
    redir_d  = 1'b0;
    ovf_d    = ovf_q;
    pop      = 1'b0;
    swap     = 1'b0;
    sb_push  = 1'b0;
    wr_tmp   = wr_ptr_q;
    cnt_tmp  = count_q;

    if (count_q != '0) begin
      if (found) begin
        pop         = 1'b1;
        out_d[pick] = head;
        rr_d        = pick + 2'd1;
      end else if (state_q == ST_REDIR) begin
        pop         = 1'b1;
        swap        = 1'b1;
        out_d[rr_q] = head;
        rr_d        = rr_q + 2'd1;
        redir_d     = 1'b1;
      end
    end

    // Pop, then displaced flit, then sbuff: sbuff sees the occupancy left by the first two.
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_tmp  = cnt_tmp - CW'(1);
    end
    if (swap) begin
      mem_d[wr_tmp] = slot_in[rr_q];
      wr_tmp        = wr_tmp + AW'(1);
      cnt_tmp       = cnt_tmp + CW'(1);
    end
    if (sbuff[FLIT_W-1]) begin
      if (cnt_tmp < CW'(DEPTH)) begin
        mem_d[wr_tmp] = sbuff;
        wr_tmp        = wr_tmp + AW'(1);
        cnt_tmp       = cnt_tmp + CW'(1);
        sb_push       = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    wr_ptr_d = wr_tmp;
    count_d  = cnt_tmp;
    full_d   = (cnt_tmp == CW'(DEPTH));
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ST_IDLE: begin
        starve_d = '0;
        if (sb_push) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pop) begin
          starve_d = '0;
          state_d  = (count_d == '0) ? ST_IDLE : ST_WAIT;
        end else if (starve_q == SW'(REDIR_THRESH - 1)) begin
          state_d = ST_REDIR;
        end else begin
          starve_d = starve_q + SW'(1);
        end
      end
      ST_REDIR: begin
        starve_d = '0;
        state_d  = (count_d == '0) ? ST_IDLE : ST_WAIT;
      end
      default: begin
        starve_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= '0;
      starve_q <= '0;
      full_q   <= 1'b0;
      redir_q  <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < 4; i++)     out_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
      starve_q <= starve_d;
      full_q   <= full_d;
      redir_q  <= redir_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
      out_q    <= out_d;
    end
  end

  assign out_e    = out_q[0];
  assign out_w    = out_q[1];
  assign out_n    = out_q[2];
  assign out_s    = out_q[3];
  assign sb_full  = full_q;
  assign sb_count = count_q;
  assign redir    = redir_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_minbd_sidebuf_ctrl.sv
// Scoreboard bench for minbd_sidebuf_ctrl: directed vectors push hand-computed
// expectations; a monitor compares them one cycle later.
module tb_minbd_sidebuf_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] sbuff = '0, in_e = '0, in_w = '0, in_n = '0, in_s = '0;
  logic [10:0] out_e, out_w, out_n, out_s;
  logic        sb_full, redir, overflow;
  logic [2:0]  sb_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [10:0] oe, ow, on, os;
    int          cnt;
    logic        full, rd, ovf;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   vec_id = 0;

  localparam logic [10:0] FE = 11'h501, FW = 11'h502, FN = 11'h503, FS = 11'h504;

  minbd_sidebuf_ctrl #(.FLIT_W(11), .DEPTH(4), .REDIR_THRESH(8)) dut (
    .clk(clk), .rst(rst), .sbuff(sbuff),
    .in_e(in_e), .in_w(in_w), .in_n(in_n), .in_s(in_s),
    .out_e(out_e), .out_w(out_w), .out_n(out_n), .out_s(out_s),
    .sb_full(sb_full), .sb_count(sb_count), .redir(redir), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %0h expected %0h", nm, id, act, exp);
    end
  endtask

  task automatic vec(input logic [10:0] sb, e, w, n, s,
                     input logic [10:0] oe, ow, on, os,
                     input int cnt, input logic full, input logic rd, input logic ovf);
    exp_t x;
    @(negedge clk);
    sbuff = sb; in_e = e; in_w = w; in_n = n; in_s = s;
    x.oe = oe; x.ow = ow; x.on = on; x.os = os;
    x.cnt = cnt; x.full = full; x.rd = rd; x.ovf = ovf; x.id = vec_id;
    exp_q.push_back(x);
    vec_id++;
  endtask

  // Monitor
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("out_e",    x.id, int'(out_e),    int'(x.oe));
        chk("out_w",    x.id, int'(out_w),    int'(x.ow));
        chk("out_n",    x.id, int'(out_n),    int'(x.on));
        chk("out_s",    x.id, int'(out_s),    int'(x.os));
        chk("sb_count", x.id, int'(sb_count), x.cnt);
        chk("sb_full",  x.id, int'(sb_full),  int'(x.full));
        chk("redir",    x.id, int'(redir),    int'(x.rd));
        chk("overflow", x.id, int'(overflow), int'(x.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sbuff = 11'($urandom); in_e = 11'($urandom); in_w = 11'($urandom);
      in_n = 11'($urandom); in_s = 11'($urandom);
      #1;
      chk("rst_outs", -1, int'({out_e, out_w, out_n, out_s}), 0);
      chk("rst_cnt",  -1, int'({sb_count, sb_full, redir, overflow}), 0);
    end
    @(negedge clk);
    sbuff = '0; in_e = '0; in_w = '0; in_n = '0; in_s = '0;
    rst = 1'b0;

    // Passthrough and round-robin reinjection.
    vec(0, 0, 0, 11'h4AC, 0,          0, 0, 11'h4AC, 0,        0, 0, 0, 0);
    vec(11'h427, 0, 0, 0, 0,          0, 0, 0, 0,              1, 0, 0, 0);
    vec(0, 0, 0, 0, 0,                11'h427, 0, 0, 0,        0, 0, 0, 0);
    vec(11'h431, 0, 0, 0, 0,          0, 0, 0, 0,              1, 0, 0, 0);
    vec(0, 0, 0, 0, 0,                0, 11'h431, 0, 0,        0, 0, 0, 0);
    vec(11'h432, 0, 0, 0, 0,          0, 0, 0, 0,              1, 0, 0, 0);
    vec(0, 0, 0, 11'h455, 0,          0, 0, 11'h455, 11'h432,  0, 0, 0, 0);

    // Starvation -> forced swap at slot 0, displaced flit later reinjected at slot 1.
    vec(11'h433, FE, FW, FN, FS,      FE, FW, FN, FS,          1, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      vec(0, FE, FW, FN, FS,          FE, FW, FN, FS,          1, 0, 0, 0);
    vec(0, FE, FW, FN, FS,            11'h433, FW, FN, FS,     1, 0, 1, 0);
    vec(0, FE, FW, FN, FS,            FE, FW, FN, FS,          1, 0, 0, 0);
    vec(0, 0, 0, 0, 0,                0, FE, 0, 0,             0, 0, 0, 0);

    // Fill, pop+push while full, overflow, drain in FIFO order.
    vec(11'h441, FE, FW, FN, FS,      FE, FW, FN, FS,          1, 0, 0, 0);
    vec(11'h442, FE, FW, FN, FS,      FE, FW, FN, FS,          2, 0, 0, 0);
    vec(11'h443, FE, FW, FN, FS,      FE, FW, FN, FS,          3, 0, 0, 0);
    vec(11'h444, FE, FW, FN, FS,      FE, FW, FN, FS,          4, 1, 0, 0);
    vec(11'h445, FE, FW, FN, 0,       FE, FW, FN, 11'h441,     4, 1, 0, 0);
    vec(11'h446, FE, FW, FN, FS,      FE, FW, FN, FS,          4, 1, 0, 1);
    vec(0, FE, FW, FN, FS,            FE, FW, FN, FS,          4, 1, 0, 1);
    vec(0, 0, FW, FN, FS,             11'h442, FW, FN, FS,     3, 0, 0, 1);
    vec(0, 0, FW, FN, FS,             11'h443, FW, FN, FS,     2, 0, 0, 1);
    vec(0, 0, FW, FN, FS,             11'h444, FW, FN, FS,     1, 0, 0, 1);
    vec(0, 0, FW, FN, FS,             11'h445, FW, FN, FS,     0, 0, 0, 1);
    vec(0, 0, FW, FN, FS,             0, FW, FN, FS,           0, 0, 0, 1);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", -1, exp_q.size(), 0);

    // Async reset while a forced swap is pending.
    @(negedge clk);
    sbuff = 11'h461; in_e = FE; in_w = FW; in_n = FN; in_s = FS;
    @(negedge clk);
    sbuff = '0;
    repeat (8) @(negedge clk);
    chk("pre_rst_cnt",   -1, int'(sb_count), 1);
    chk("pre_rst_redir", -1, int'(redir), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_outs", -1, int'({out_e, out_w, out_n, out_s}), 0);
    chk("async_cnt",  -1, int'(sb_count), 0);
    chk("async_ovf",  -1, int'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_redir", -1, int'(redir), 0);
      chk("post_rst_cnt",   -1, int'(sb_count), 0);
      chk("post_rst_out_e", -1, int'(out_e), int'(FE));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
